// File: rtl/nh_pixel_streamer_if.sv
// Pixel-streamer bus: RAM read port plus the {valid, pixel} stream into the pooling window.
// NH_STREAM_SIDEBAND_EN adds the sof/eol sideband to the stream.
interface nh_pixel_streamer_if #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 10
);
  logic              ram_rd_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rd_data;
  logic              shift_out_rdy;
  logic [DATA_W-1:0] shift_out;
`ifdef NH_STREAM_SIDEBAND_EN
  logic              sof;
  logic              eol;

  modport master (
    output ram_rd_en, ram_addr, shift_out_rdy, shift_out, sof, eol,
    input  ram_rd_data
  );
  modport slave (
    input  ram_rd_en, ram_addr, shift_out_rdy, shift_out, sof, eol,
    output ram_rd_data
  );
`else
  modport master (
    output ram_rd_en, ram_addr, shift_out_rdy, shift_out,
    input  ram_rd_data
  );
  modport slave (
    input  ram_rd_en, ram_addr, shift_out_rdy, shift_out,
    output ram_rd_data
  );
`endif
endinterface

// File: rtl/nh_pixel_streamer.sv
// Raster-order feature-map reader feeding the 2x2 max-pool window from a synchronous-read RAM.
// Optional sof/eol sideband outputs are built when NH_STREAM_SIDEBAND_EN is defined.
module nh_pixel_streamer #(
  parameter int DATA_W    = 24,
  parameter int FM_WIDTH  = 22,
  parameter int FM_HEIGHT = 22,
  parameter int ADDR_W    = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  pause,
  output logic                  busy,
  output logic                  done,
  nh_pixel_streamer_if.master   bus
);

  localparam int COL_W = (FM_WIDTH  > 1) ? $clog2(FM_WIDTH)  : 1;
  localparam int ROW_W = (FM_HEIGHT > 1) ? $clog2(FM_HEIGHT) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(FM_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(FM_HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic              last_pix;
  logic              rdy_q;
  logic              done_q;
  logic [DATA_W-1:0] pix_hold;

  assign last_pix = (col == LAST_COL) && (row == LAST_ROW);

  // NOTE: every sequential process uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: defaults first, so no path through the case leaves an output unassigned (no latch).
  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = READ;
      end
      READ: begin
        rd_en = ~pause;
        if (rd_en && last_pix) state_nxt = DRAIN;
      end
      DRAIN: begin
        // The only pixel left is already in flight; pause cannot hold it back.
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address and raster counters advance only on issued reads, so a pause simply freezes them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr <= '0;
      col  <= '0;
      row  <= '0;
    end else if (state == DRAIN) begin
      addr <= '0;
      col  <= '0;
      row  <= '0;
    end else if (rd_en) begin
      addr <= addr + 1'b1;
      if (col == LAST_COL) begin
        col <= '0;
        if (row != LAST_ROW) row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdy_q    <= 1'b0;
      done_q   <= 1'b0;
      pix_hold <= '0;
    end else begin
      rdy_q  <= rd_en;
      done_q <= rd_en & last_pix;
      if (rdy_q) pix_hold <= bus.ram_rd_data;
    end
  end

  // RAM data arrives in the cycle after the read, so it is forwarded directly while valid
  // and the captured copy holds the last pixel otherwise.
  assign bus.shift_out     = rdy_q ? bus.ram_rd_data : pix_hold;
  assign bus.shift_out_rdy = rdy_q;
  assign bus.ram_rd_en     = rd_en;
  assign bus.ram_addr      = addr;
  assign busy              = (state != IDLE);
  assign done              = done_q;

`ifdef NH_STREAM_SIDEBAND_EN
  logic sof_q;
  logic eol_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sof_q <= 1'b0;
      eol_q <= 1'b0;
    end else begin
      sof_q <= rd_en && (col == '0) && (row == '0);
      eol_q <= rd_en && (col == LAST_COL);
    end
  end

  assign bus.sof = sof_q;
  assign bus.eol = eol_q;
`endif

endmodule
